// File: rtl/fc_pkg.sv
// Shared widths, FSM encoding and pipeline bundles
// for the FC output writeback stage.
package fc_pkg;

  localparam int OUTNEURON = 10;
  localparam int ACCUM_DATA_WIDTH_FC = 44;
  localparam int DATA_WIDTH_FC = 16;
  localparam int FRAC_SHIFT = 8;
  localparam int FC_OUTNEURON_ADDR_WIDTH = 9;
  localparam int FC_COUNT_OUT_NEURON_BITWIDTH = 4;

  localparam int SUM_W = ACCUM_DATA_WIDTH_FC + 1;
  localparam int RND_W = SUM_W + 1;
  localparam int IDX_W = FC_COUNT_OUT_NEURON_BITWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } fc_state_t;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [SUM_W-1:0]  sum;
  } fc_s1_t;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [RND_W-1:0]  rnd;
  } fc_s2_t;

endpackage

// File: rtl/fc_round_sat.sv
// Round-half-up rescale and signed saturation
// with optional ReLU, purely combinational.
module fc_round_sat #(
  parameter int SUM_W = 45,
  parameter int DW    = 16,
  parameter int FS    = 8,
  parameter int RELU  = 0
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic signed [SUM_W:0]   rnd,
  input  logic signed [SUM_W:0]   rnd_q,
  output logic signed [DW-1:0]    sat_data,
  output logic                    clipped
);

  localparam logic signed [SUM_W:0] HALF =
    {{(SUM_W-FS+1){1'b0}}, 1'b1, {(FS-1){1'b0}}};
  localparam logic signed [SUM_W:0] MAXV =
    {{(SUM_W+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SUM_W:0] MINV =
    {{(SUM_W+2-DW){1'b1}}, {(DW-1){1'b0}}};

  logic signed [SUM_W:0] ext;

  assign ext = $signed({sum[SUM_W-1], sum});
  assign rnd = (ext + HALF) >>> FS;

  always_comb begin
    sat_data = rnd_q[DW-1:0];
    clipped  = 1'b0;
    if (rnd_q > MAXV) begin
      sat_data = {1'b0, {(DW-1){1'b1}}};
      clipped  = 1'b1;
    end else if (rnd_q < MINV) begin
      sat_data = {1'b1, {(DW-1){1'b0}}};
      // under ReLU a negative clip becomes 0, not a saturation
      clipped  = (RELU == 0);
    end
    if ((RELU != 0) && sat_data[DW-1]) begin
      sat_data = '0;
    end
  end

endmodule

// File: rtl/fc_out_writeback.sv
// FC output stage: bias, round, saturate, write
// each neuron and track the argmax class.
module fc_out_writeback
  import fc_pkg::*;
#(
  parameter int RELU_EN = 0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                accum_valid,
  input  logic signed [ACCUM_DATA_WIDTH_FC-1:0] accum_result,
  output logic [IDX_W-1:0]                    bias_addr,
  input  logic signed [DATA_WIDTH_FC-1:0]     bias_q,
  output logic                                out_wren,
  output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]  out_addr,
  output logic signed [DATA_WIDTH_FC-1:0]     out_data,
  output logic [IDX_W-1:0]                    sat_count,
  output logic                                proto_err,
  output logic [IDX_W-1:0]                    class_idx,
  output logic                                done
);

  localparam int DW = DATA_WIDTH_FC;
  localparam int AW = FC_OUTNEURON_ADDR_WIDTH;
  localparam int AC = ACCUM_DATA_WIDTH_FC;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(OUTNEURON - 1);

  fc_state_t state;
  logic [IDX_W-1:0] in_idx;
  fc_s1_t s1;
  fc_s2_t s2;
  logic signed [DW-1:0] max_val;

  logic signed [SUM_W-1:0] bias_sh;
  logic signed [SUM_W-1:0] sum_next;
  logic signed [RND_W-1:0] rnd;
  logic signed [DW-1:0] sat_data;
  logic clipped;
  logic busy;
  logic abort;
  logic accept;

  assign busy   = (state == ST_RUN) || (state == ST_FLUSH);
  assign abort  = busy && !enable;
  assign accept = (state == ST_RUN) && enable && accum_valid;
  assign bias_addr = in_idx;

  assign bias_sh = $signed({
    {(SUM_W-DW-FRAC_SHIFT){bias_q[DW-1]}},
    bias_q,
    {FRAC_SHIFT{1'b0}}
  });
  assign sum_next = $signed({accum_result[AC-1], accum_result})
                  + bias_sh;

  fc_round_sat #(
    .SUM_W (SUM_W),
    .DW    (DW),
    .FS    (FRAC_SHIFT),
    .RELU  (RELU_EN)
  ) u_round_sat (
    .sum      ($signed(s1.sum)),
    .rnd      (rnd),
    .rnd_q    ($signed(s2.rnd)),
    .sat_data (sat_data),
    .clipped  (clipped)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_idx    <= '0;
      s1        <= '0;
      s2        <= '0;
      max_val   <= '0;
      out_wren  <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      sat_count <= '0;
      proto_err <= 1'b0;
      class_idx <= '0;
      done      <= 1'b0;
    end else begin
      out_wren <= 1'b0;

      s1.valid <= accept;
      s1.idx   <= in_idx;
      s1.sum   <= sum_next;

      s2.valid <= s1.valid;
      s2.idx   <= s1.idx;
      s2.rnd   <= rnd;

      if (s2.valid && !abort) begin
        out_wren <= 1'b1;
        out_addr <= {{(AW-IDX_W){1'b0}}, s2.idx};
        out_data <= sat_data;
        if (clipped) sat_count <= sat_count + 1'b1;
      end

      // strict '>' keeps the lowest index on ties
      if (out_wren &&
          ((out_addr == '0) || (out_data > max_val))) begin
        max_val   <= out_data;
        class_idx <= out_addr[IDX_W-1:0];
      end

      if (accum_valid && (state != ST_RUN)) proto_err <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (enable) begin
            state     <= ST_RUN;
            in_idx    <= '0;
            sat_count <= '0;
            max_val   <= '0;
            class_idx <= '0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state    <= ST_IDLE;
            s1.valid <= 1'b0;
            s2.valid <= 1'b0;
          end else if (accept) begin
            if (in_idx == LAST) begin
              in_idx <= '0;
              state  <= ST_FLUSH;
            end else begin
              in_idx <= in_idx + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (abort) begin
            state    <= ST_IDLE;
            s1.valid <= 1'b0;
            s2.valid <= 1'b0;
          end else if (!s1.valid && !s2.valid) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!enable) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_out_writeback.sv
// Scoreboard bench for fc_out_writeback, plain
// and ReLU instances driven in lockstep.
module tb_fc_out_writeback;
  import fc_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic accum_valid;
  logic signed [43:0] accum_result;
  logic signed [15:0] bias_q;

  logic [3:0] bias_addr, sat_count, class_idx;
  logic out_wren, proto_err, done;
  logic [8:0] out_addr;
  logic signed [15:0] out_data;

  logic [3:0] bias_addr_r, sat_count_r, class_idx_r;
  logic out_wren_r, proto_err_r, done_r;
  logic [8:0] out_addr_r;
  logic signed [15:0] out_data_r;

  always #5 clock = ~clock;

  fc_out_writeback #(.RELU_EN(0)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .accum_valid(accum_valid), .accum_result(accum_result),
    .bias_addr(bias_addr), .bias_q(bias_q),
    .out_wren(out_wren), .out_addr(out_addr),
    .out_data(out_data), .sat_count(sat_count),
    .proto_err(proto_err), .class_idx(class_idx),
    .done(done)
  );

  fc_out_writeback #(.RELU_EN(1)) dut_relu (
    .clock(clock), .reset(reset), .enable(enable),
    .accum_valid(accum_valid), .accum_result(accum_result),
    .bias_addr(bias_addr_r), .bias_q(bias_q),
    .out_wren(out_wren_r), .out_addr(out_addr_r),
    .out_data(out_data_r), .sat_count(sat_count_r),
    .proto_err(proto_err_r), .class_idx(class_idx_r),
    .done(done_r)
  );

  typedef struct {
    logic [8:0] addr;
    logic signed [15:0] data;
    int cyc;
  } exp_t;

  typedef struct {
    logic signed [43:0] a;
    logic signed [15:0] b;
    logic signed [15:0] e0;
    logic signed [15:0] e1;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_wr = -1;
  int nidx = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (out_wren) begin
      if (q0.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("addr", out_addr, e.addr);
        chk("data", out_data, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
      last_wr = cyc;
    end
  end

  always @(negedge clock) begin
    if (out_wren_r) begin
      if (q1.size() == 0) begin
        chk("relu_unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("relu_addr", out_addr_r, e.addr);
        chk("relu_data", out_data_r, e.data);
        chk("relu_wr_cycle", cyc, e.cyc);
      end
    end
  end

  // mode 0: accepted and written, 1: accepted but
  // lost to abort/reset, 2: ignored outside RUN
  task automatic pulse(input vec_t v, input int mode,
                       input int gap);
    accum_valid  = 1'b1;
    accum_result = v.a;
    bias_q       = v.b;
    if (mode != 2) begin
      chk("bias_addr", bias_addr, nidx);
      if (mode == 0) begin
        q0.push_back('{addr: 9'(nidx), data: v.e0,
                       cyc: cyc + 3});
        q1.push_back('{addr: 9'(nidx), data: v.e1,
                       cyc: cyc + 3});
      end
      nidx++;
    end
    @(posedge clock); #1;
    accum_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic start_pass();
    enable = 1'b1;
    nidx = 0;
    @(posedge clock); #1;
  endtask

  task automatic end_pass();
    enable = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("done_cleared", done, 0);
    @(posedge clock); #1;
  endtask

  task automatic wait_done(input string tag,
                           input int cls, input int sat,
                           input int cls_r, input int sat_r);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_done"}, done, 1);
    if (done) chk({tag, "_done_latency"}, cyc, last_wr + 1);
    chk({tag, "_class_idx"}, class_idx, cls);
    chk({tag, "_sat_count"}, sat_count, sat);
    chk({tag, "_relu_done"}, done_r, 1);
    chk({tag, "_relu_class_idx"}, class_idx_r, cls_r);
    chk({tag, "_relu_sat_count"}, sat_count_r, sat_r);
    chk({tag, "_queue_drained"}, q0.size() + q1.size(), 0);
  endtask

  vec_t v;
  vec_t rnd_v[10];
  int tie_k[10] = '{5, 9, 9, 3, -4, 2, 9, 1, 0, 7};
  int tie_r[10] = '{5, 9, 9, 3, 0, 2, 9, 1, 0, 7};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rnd_v[0] = '{44'sh17F, 16'sd0, 16'sd1, 16'sd1};
    rnd_v[1] = '{44'sh180, 16'sd0, 16'sd2, 16'sd2};
    rnd_v[2] = '{-44'sh180, 16'sd0, -16'sd1, 16'sd0};
    rnd_v[3] = '{44'sd1 <<< 40, 16'sd0,
                 16'sh7FFF, 16'sh7FFF};
    rnd_v[4] = '{-(44'sd1 <<< 40), 16'sd0,
                 -16'sd32768, 16'sd0};
    rnd_v[5] = '{44'sh100, -16'sd2, -16'sd1, 16'sd0};
    rnd_v[6] = '{44'sh80, 16'sd3, 16'sd4, 16'sd4};
    rnd_v[7] = '{44'sh7F, 16'sd0, 16'sd0, 16'sd0};
    rnd_v[8] = '{-44'sh81, 16'sd0, -16'sd1, 16'sd0};
    rnd_v[9] = '{-44'sh80, 16'sd0, 16'sd0, 16'sd0};

    reset = 1'b1;
    enable = 1'b0;
    accum_valid = 1'b0;
    accum_result = '0;
    bias_q = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_wren", out_wren, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_class_idx", class_idx, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_bias_addr", bias_addr, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // ramp: out k at address k, largest last
    start_pass();
    for (int k = 0; k < 10; k++) begin
      v = '{44'(k) <<< 8, 16'sd0, 16'(k), 16'(k)};
      pulse(v, 0, 1);
    end
    wait_done("ramp", 9, 0, 9, 0);
    end_pass();

    // rounding, saturation, bias and ReLU corners
    start_pass();
    for (int k = 0; k < 10; k++) pulse(rnd_v[k], 0, 2);
    wait_done("round", 3, 2, 3, 1);
    end_pass();

    // back-to-back pulses with a tied maximum
    start_pass();
    for (int k = 0; k < 10; k++) begin
      v = '{44'(tie_k[k]) <<< 8, 16'sd0,
            16'(tie_k[k]), 16'(tie_r[k])};
      pulse(v, 0, 0);
    end
    wait_done("tie", 1, 0, 1, 0);
    end_pass();

    // abort right after neuron 4: 3 and 4 never land
    start_pass();
    for (int k = 0; k < 5; k++) begin
      v = '{44'(k + 1) <<< 8, 16'sd0,
            16'(k + 1), 16'(k + 1)};
      pulse(v, (k < 3) ? 0 : 1, 0);
    end
    enable = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    chk("abort_queue_drained", q0.size() + q1.size(), 0);
    chk("abort_done", done, 0);
    chk("abort_proto_err", proto_err, 0);

    // full pass then a stray pulse while flushing
    start_pass();
    for (int k = 0; k < 10; k++) begin
      v = '{44'sd0, 16'(k), 16'(k), 16'(k)};
      pulse(v, 0, 0);
    end
    v = '{44'sh7F00, 16'sd0, 16'sd0, 16'sd0};
    pulse(v, 2, 0);
    wait_done("flush", 9, 0, 9, 0);
    chk("proto_err", proto_err, 1);
    chk("relu_proto_err", proto_err_r, 1);
    end_pass();

    // reset in the middle of a pass
    start_pass();
    v = '{44'sh100, 16'sd0, 16'sd1, 16'sd1};
    pulse(v, 0, 0);
    v = '{44'sd1 <<< 40, 16'sd0, 16'sh7FFF, 16'sh7FFF};
    pulse(v, 0, 4);
    chk("mid_sat_count", sat_count, 1);
    chk("mid_class_idx", class_idx, 1);
    v = '{44'sh500, 16'sd0, 16'sd5, 16'sd5};
    pulse(v, 1, 0);
    reset = 1'b1;
    enable = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("mrst_out_wren", out_wren, 0);
    chk("mrst_out_addr", out_addr, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_sat_count", sat_count, 0);
    chk("mrst_class_idx", class_idx, 0);
    chk("mrst_proto_err", proto_err, 0);
    chk("mrst_done", done, 0);
    chk("mrst_bias_addr", bias_addr, 0);
    reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    chk("final_queue_drained", q0.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
